// File: rtl/pmem_arbiter_if.sv
// Line-granular physical-memory port: read/write strobes, address and write
// line toward memory, completion pulse and read line back.
interface pmem_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
    logic              resp;
    logic [LINE_W-1:0] rdata;

    modport master (
        output read, write, address, wdata,
        input  resp, rdata
    );

    modport slave (
        input  read, write, address, wdata,
        output resp, rdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one line-based memory port between the I-cache and the D-cache,
// one line transaction per grant, round-robin on contention.
module pmem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pmem_arbiter_if.slave  i_pmem,
    pmem_arbiter_if.slave  d_pmem,
    pmem_arbiter_if.master pmem
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_r;
    logic              last_grant_r;   // 1'b0 = I, 1'b1 = D
    logic              i_active_s;
    logic              d_active_s;
    logic              read_s;
    logic              write_s;
    logic [ADDR_W-1:0] address_s;
    logic [LINE_W-1:0] wdata_s;
    logic              i_resp_s;
    logic              d_resp_s;

    assign i_active_s = i_pmem.read | i_pmem.write;
    assign d_active_s = d_pmem.read | d_pmem.write;

    // Grant/release sequencing; every transaction returns through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_active_s && d_active_s) begin
                        if (last_grant_r) begin
                            state_r      <= BUSY_I;
                            last_grant_r <= 1'b0;
                        end else begin
                            state_r      <= BUSY_D;
                            last_grant_r <= 1'b1;
                        end
                    end else if (i_active_s) begin
                        state_r      <= BUSY_I;
                        last_grant_r <= 1'b0;
                    end else if (d_active_s) begin
                        state_r      <= BUSY_D;
                        last_grant_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY_I: begin
                    if (pmem.resp || !i_active_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BUSY_I;
                    end
                end
                BUSY_D: begin
                    if (pmem.resp || !d_active_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= BUSY_D;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Forward the owner's live request; route completion only to the owner.
    always_comb begin
        read_s    = 1'b0;
        write_s   = 1'b0;
        address_s = {ADDR_W{1'b0}};
        wdata_s   = {LINE_W{1'b0}};
        i_resp_s  = 1'b0;
        d_resp_s  = 1'b0;
        case (state_r)
            BUSY_I: begin
                read_s    = i_pmem.read;
                write_s   = i_pmem.write;
                address_s = i_pmem.address;
                wdata_s   = i_pmem.wdata;
                i_resp_s  = pmem.resp;
            end
            BUSY_D: begin
                read_s    = d_pmem.read;
                write_s   = d_pmem.write;
                address_s = d_pmem.address;
                wdata_s   = d_pmem.wdata;
                d_resp_s  = pmem.resp;
            end
            default: begin
                read_s   = 1'b0;
                write_s  = 1'b0;
                i_resp_s = 1'b0;
                d_resp_s = 1'b0;
            end
        endcase
    end

    assign pmem.read    = read_s;
    assign pmem.write   = write_s;
    assign pmem.address = address_s;
    assign pmem.wdata   = wdata_s;
    assign i_pmem.resp  = i_resp_s;
    assign d_pmem.resp  = d_resp_s;
    // Read data is broadcast; only the matching resp qualifies it.
    assign i_pmem.rdata = pmem.rdata;
    assign d_pmem.rdata = pmem.rdata;
endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Shares one physical-memory line port between the instruction cache and the data cache. Each cache sees a private pmem-style interface. The arbiter grants the shared port to one cache per line transaction, using round-robin priority on contention. It forwards that cache's request and routes the response back, which lets two copies of the line-based `cache` sit in front of a single main memory.

## Interface
- `LINE_W`, default 256: line width in bits, for wdata and rdata.
- `ADDR_W`, default 32: address width.

Ports:
- `clk`  in  1: sole clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `i_pmem_read`  in  1: I-cache line read request.
- `i_pmem_write`  in  1: I-cache line write request.
- `i_pmem_address`  in  ADDR_W: I-cache line address.
- `i_pmem_wdata`  in  LINE_W: I-cache write line.
- `i_pmem_resp`  out  1: I-cache transaction complete.
- `i_pmem_rdata`  out  LINE_W: I-cache read line.
- `d_pmem_read`, `d_pmem_write`, `d_pmem_address`, `d_pmem_wdata`, `d_pmem_resp`, `d_pmem_rdata`: D-cache equivalents, same directions and widths.
- `pmem_read`  out  1: shared memory read strobe.
- `pmem_write`  out  1: shared memory write strobe.
- `pmem_address`  out  ADDR_W: shared memory address.
- `pmem_wdata`  out  LINE_W: shared memory write line.
- `pmem_resp`  in  1: memory completion, one cycle per transaction.
- `pmem_rdata`  in  LINE_W: memory read line, valid with `pmem_resp`.

## Operation

**States**
- IDLE
- BUSY_I
- BUSY_D
- Registers: state, plus `last_grant` (0 = I, 1 = D).

**Requester activity**
- A requester is active when its read or write input is high.
- read and write both high from one requester is illegal. Behaviour is undefined, but the bench flags it with an assertion.

**IDLE**
- All `pmem_*` outputs are 0 and both `*_pmem_resp` are 0.
- Only I active: next state BUSY_I.
- Only D active: next state BUSY_D.
- Both active: grant the requester that is not `last_grant`, then update `last_grant` to the granted requester. With `last_grant`=I, D wins; with `last_grant`=D, I wins.
- Neither active: stay in IDLE.

**BUSY_x**
- `pmem_read`, `pmem_write`, `pmem_address` and `pmem_wdata` are driven combinationally from requester x's live inputs.
- The other requester's request is held pending and left unacknowledged.

**Completion**
- In BUSY_x with `pmem_resp`=1:
  - `x_pmem_resp`=1 in that same cycle.
  - Next state is IDLE, unconditionally.
- The mandatory IDLE cycle after each response lets the finishing cache drop its request, so a stale request cannot re-grant.

**Data routing**
- `pmem_rdata` feeds both `i_pmem_rdata` and `d_pmem_rdata` directly.
- Only the matching `*_resp` qualifies that data.

**Abandonment**
- If requester x drops both strobes while in BUSY_x without a `pmem_resp`: return to IDLE next cycle, with `last_grant` unchanged.

**Spurious responses**
- `pmem_resp` in IDLE is ignored: no `*_resp` is issued and there is no state change.

**Reset**
- `rst_n`=0 forces IDLE and `last_grant`=D (so I wins the first tie), asynchronously.
- `pmem_read` and `pmem_write` drop in the same cycle, including mid-transaction.
- Reset values: all outputs 0.

## Timing
- Grant latency: a request first visible in IDLE at cycle n gives `pmem_read`/`pmem_write` asserted in cycle n+1.
- Response path is combinational: `pmem_resp` to `x_pmem_resp` with zero cycles.
- Minimum spacing between back-to-back transactions is one IDLE cycle. Single-requester throughput is one transaction per (memory latency + 2) cycles.
- No combinational path from `pmem_resp` to `pmem_read`/`pmem_write`; strobes change only on state change.
- Registered outputs: none besides state. The `pmem_*` outputs are muxes selected by state.
- Starvation bound: a pending requester is granted within one foreign transaction.

## Test plan
- **Reset during read:** D read to 0x100, `rst_n` pulled low while BUSY_D -> `pmem_read` is 0 in that same cycle, state is IDLE, all outputs are 0, and no `d_pmem_resp` is issued.
- **Single I read:** I read to 0x40; memory returns 0xAA..AA after 4 cycles -> `pmem_read`=1 from cycle 1, `i_pmem_resp`=1 with rdata 0xAA..AA in the response cycle, `d_pmem_resp` stays 0.
- **Simultaneous requests after reset:** I read 0x80 and D write 0x200 with wdata 0x55..55 in the same cycle -> I is served first. Then one IDLE cycle, then `pmem_write`=1 at 0x200 with wdata 0x55..55, and `d_pmem_resp` follows.
- **Round-robin fairness:** both requesters continuously re-request (I reads 0x0, D reads 0x20) -> grants strictly alternate I, D, I, D over 8 transactions, with no requester served twice in a row.
- **Back-to-back single requester:** D issues 3 reads, each re-asserted right after its resp -> each grant is preceded by exactly one IDLE cycle, and the same stale request is never granted twice.
- **Spurious response:** `pmem_resp` pulsed in IDLE -> no `*_resp` asserted and state remains IDLE.
